// File: rtl/imem_responder_if.sv
// imem_responder_if
//   Bundles the fetch request/response and program-loader signals of the
//   instruction-memory responder.
//   Modports:
//     master - fetch stage / loader source (drives requests and load bytes)
//     slave  - imem_responder
//   Signals:
//     req_pc, req_valid, hold, flush             fetch request and pipeline control
//     instr_out, instr_pc, instr_valid           registered response
//     fault_misaligned, fault_range              response fault flags
//     load_start, load_end, load_valid, load_byte  loader input
//     load_ready, load_busy, load_count          loader status
//     parity_err                                 only when IMEM_PARITY_EN is defined
interface imem_responder_if #(
  parameter int unsigned DEPTH_WORDS = 1024
) ();
  localparam int unsigned CW = $clog2(DEPTH_WORDS) + 1;

  logic [31:0]   req_pc;
  logic          req_valid;
  logic          hold;
  logic          flush;
  logic [31:0]   instr_out;
  logic [31:0]   instr_pc;
  logic          instr_valid;
  logic          fault_misaligned;
  logic          fault_range;
  logic          load_start;
  logic          load_end;
  logic          load_valid;
  logic [7:0]    load_byte;
  logic          load_ready;
  logic          load_busy;
  logic [CW-1:0] load_count;
`ifdef IMEM_PARITY_EN
  logic          parity_err;

  modport master (
    output req_pc, req_valid, hold, flush,
    output load_start, load_end, load_valid, load_byte,
    input  instr_out, instr_pc, instr_valid, fault_misaligned, fault_range,
    input  load_ready, load_busy, load_count, parity_err
  );

  modport slave (
    input  req_pc, req_valid, hold, flush,
    input  load_start, load_end, load_valid, load_byte,
    output instr_out, instr_pc, instr_valid, fault_misaligned, fault_range,
    output load_ready, load_busy, load_count, parity_err
  );
`else
  modport master (
    output req_pc, req_valid, hold, flush,
    output load_start, load_end, load_valid, load_byte,
    input  instr_out, instr_pc, instr_valid, fault_misaligned, fault_range,
    input  load_ready, load_busy, load_count
  );

  modport slave (
    input  req_pc, req_valid, hold, flush,
    input  load_start, load_end, load_valid, load_byte,
    output instr_out, instr_pc, instr_valid, fault_misaligned, fault_range,
    output load_ready, load_busy, load_count
  );
`endif
endinterface

// File: rtl/imem_responder.sv
// imem_responder
//   Instruction memory for the PC-only fetch stage. A request in cycle N is
//   answered after edge N+1 (synchronous read, registered response), honouring
//   flush > hold > suppression > misaligned > range > normal read.
//   A byte-serial loader FSM (L_IDLE / L_COLLECT / L_WRITE) assembles
//   little-endian words and owns the single write port; fetch responses are
//   suppressed while it is busy.
//   Optional feature macro: IMEM_PARITY_EN (33rd even-parity bit per word,
//   checked on every in-range read, reported on bus.parity_err).
//   Ports:
//     clk  - system clock (rising edge)
//     rst  - asynchronous active-high reset
//     bus  - imem_responder_if.slave (fetch request/response + loader)
module imem_responder #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] NOP_INSTR   = 32'h0000_0013
) (
  input  logic             clk,
  input  logic             rst,
  imem_responder_if.slave  bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam int unsigned CW = AW + 1;
`ifdef IMEM_PARITY_EN
  localparam int unsigned MW = 33;
`else
  localparam int unsigned MW = 32;
`endif

  typedef enum logic [1:0] {
    L_IDLE    = 2'd0,
    L_COLLECT = 2'd1,
    L_WRITE   = 2'd2
  } lstate_t;

  // ---------------------------------------------------------------- loader
  lstate_t       r_state, w_state_nxt;
  logic [1:0]    r_byte_cnt, w_byte_cnt_nxt;
  logic [31:0]   r_word, w_word_nxt;
  logic [AW-1:0] r_load_addr, w_load_addr_nxt;
  logic [CW-1:0] r_load_count, w_load_count_nxt;
  logic          r_busy;
  logic          r_ready;
  logic          w_we;
  logic [MW-1:0] w_wdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= L_IDLE;
      r_byte_cnt   <= '0;
      r_word       <= '0;
      r_load_addr  <= '0;
      r_load_count <= '0;
      r_busy       <= 1'b0;
      r_ready      <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_byte_cnt   <= w_byte_cnt_nxt;
      r_word       <= w_word_nxt;
      r_load_addr  <= w_load_addr_nxt;
      r_load_count <= w_load_count_nxt;
      r_busy       <= (w_state_nxt != L_IDLE);
      r_ready      <= (w_state_nxt == L_COLLECT);
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_byte_cnt_nxt   = r_byte_cnt;
    w_word_nxt       = r_word;
    w_load_addr_nxt  = r_load_addr;
    w_load_count_nxt = r_load_count;
    w_we             = 1'b0;
    unique case (r_state)
      L_IDLE: begin
        if (bus.load_start) begin
          w_state_nxt      = L_COLLECT;
          w_byte_cnt_nxt   = '0;
          w_load_addr_nxt  = '0;
          w_load_count_nxt = '0;
        end
      end
      L_COLLECT: begin
        if (bus.load_start) begin
          w_byte_cnt_nxt   = '0;
          w_load_addr_nxt  = '0;
          w_load_count_nxt = '0;
        end else if (bus.load_end) begin
          // partially assembled word is simply dropped
          w_state_nxt = L_IDLE;
        end else if (bus.load_valid) begin
          w_word_nxt[{r_byte_cnt, 3'b000} +: 8] = bus.load_byte;
          w_byte_cnt_nxt = r_byte_cnt + 2'd1;
          if (r_byte_cnt == 2'd3) begin
            w_state_nxt = L_WRITE;
          end
        end
      end
      L_WRITE: begin
        // the write always completes, even when start/end arrive this cycle
        w_we             = 1'b1;
        w_byte_cnt_nxt   = '0;
        w_load_addr_nxt  = r_load_addr + AW'(1);
        w_load_count_nxt = r_load_count + CW'(1);
        if (bus.load_start) begin
          w_state_nxt      = L_COLLECT;
          w_load_addr_nxt  = '0;
          w_load_count_nxt = '0;
        end else if (bus.load_end || (r_load_addr == AW'(DEPTH_WORDS - 1))) begin
          w_state_nxt = L_IDLE;
        end else begin
          w_state_nxt = L_COLLECT;
        end
      end
      default: w_state_nxt = L_IDLE;
    endcase
  end

`ifdef IMEM_PARITY_EN
  assign w_wdata = {^r_word, r_word};
`else
  assign w_wdata = r_word;
`endif

  // ---------------------------------------------------------------- memory
  logic [MW-1:0] r_mem [DEPTH_WORDS];
  logic [MW-1:0] r_rdata;
  logic [AW-1:0] w_rd_idx;

  assign w_rd_idx = bus.req_pc[AW+1:2];

  // Read data is held together with the response flags under hold, so the
  // output mux below reproduces the frozen instruction.
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[r_load_addr] <= w_wdata;
    end
    if (!bus.hold) begin
      r_rdata <= r_mem[w_rd_idx];
    end
  end

  // -------------------------------------------------------------- response
  logic        r_use_mem;
  logic        r_valid;
  logic        r_mis;
  logic        r_rng;
  logic [31:0] r_pc;
  logic        w_out_of_range;
  logic        w_par_bad;

  assign w_out_of_range = (bus.req_pc[31:2] >= 30'(DEPTH_WORDS));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_use_mem <= 1'b0;
      r_valid   <= 1'b0;
      r_mis     <= 1'b0;
      r_rng     <= 1'b0;
      r_pc      <= '0;
    end else if (bus.flush) begin
      r_use_mem <= 1'b0;
      r_valid   <= 1'b0;
      r_mis     <= 1'b0;
      r_rng     <= 1'b0;
      r_pc      <= bus.req_pc;
    end else if (bus.hold) begin
      r_use_mem <= r_use_mem;
    end else if (r_busy || !bus.req_valid) begin
      r_use_mem <= 1'b0;
      r_valid   <= 1'b0;
      r_mis     <= 1'b0;
      r_rng     <= 1'b0;
    end else if (bus.req_pc[1:0] != 2'b00) begin
      r_use_mem <= 1'b0;
      r_valid   <= 1'b1;
      r_mis     <= 1'b1;
      r_rng     <= 1'b0;
      r_pc      <= bus.req_pc;
    end else if (w_out_of_range) begin
      r_use_mem <= 1'b0;
      r_valid   <= 1'b1;
      r_mis     <= 1'b0;
      r_rng     <= 1'b1;
      r_pc      <= bus.req_pc;
    end else begin
      r_use_mem <= 1'b1;
      r_valid   <= 1'b1;
      r_mis     <= 1'b0;
      r_rng     <= 1'b0;
      r_pc      <= bus.req_pc;
    end
  end

`ifdef IMEM_PARITY_EN
  // stored bit is even parity of the data, so a clean word XORs to zero
  assign w_par_bad      = ^r_rdata;
  assign bus.parity_err = r_use_mem & w_par_bad;
`else
  assign w_par_bad = 1'b0;
`endif

  assign bus.instr_out        = (r_use_mem && !w_par_bad) ? r_rdata[31:0] : NOP_INSTR;
  assign bus.instr_pc         = r_pc;
  assign bus.instr_valid      = r_valid;
  assign bus.fault_misaligned = r_mis;
  assign bus.fault_range      = r_rng;
  assign bus.load_ready       = r_ready;
  assign bus.load_busy        = r_busy;
  assign bus.load_count       = r_load_count;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AWT   = $clog2(DEPTH);
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imem_responder_if #(.DEPTH_WORDS(DEPTH)) bus ();

  imem_responder #(.DEPTH_WORDS(DEPTH), .NOP_INSTR(NOP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  // reference: memory image and response/loader state from the rules
  logic [31:0] ref_mem [DEPTH];
  logic [31:0] m_out, m_pc;
  logic        m_valid, m_mis, m_rng, m_busy;
  int unsigned ld_addr, ld_count, ld_nbytes;
  logic [31:0] ld_word;

  typedef struct {
    logic [31:0] pc;
    logic        v, h, f;
    logic [31:0] eout, epc;
    logic        ev, em, er, cpc;
  } vec_t;
  vec_t vt [14];

  function automatic vec_t mk(logic [31:0] pc, logic v, logic h, logic f,
                              logic [31:0] eout, logic [31:0] epc,
                              logic ev, logic em, logic er, logic cpc);
    vec_t r;
    r.pc = pc; r.v = v; r.h = h; r.f = f;
    r.eout = eout; r.epc = epc; r.ev = ev; r.em = em; r.er = er; r.cpc = cpc;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic void model_step(logic [31:0] pc, logic v, logic h, logic f, logic busy);
    if (f) begin
      m_valid = 1'b0; m_out = NOP; m_mis = 1'b0; m_rng = 1'b0; m_pc = pc;
    end else if (h) begin
      // response frozen
    end else if (busy || !v) begin
      m_valid = 1'b0; m_out = NOP; m_mis = 1'b0; m_rng = 1'b0;
    end else if (pc % 4 != 0) begin
      m_valid = 1'b1; m_out = NOP; m_mis = 1'b1; m_rng = 1'b0; m_pc = pc;
    end else if ((pc / 4) >= DEPTH) begin
      m_valid = 1'b1; m_out = NOP; m_mis = 1'b0; m_rng = 1'b1; m_pc = pc;
    end else begin
      m_valid = 1'b1; m_out = ref_mem[pc[AWT+1:2]]; m_mis = 1'b0; m_rng = 1'b0; m_pc = pc;
    end
  endfunction

  task automatic cyc();
    @(posedge clk);
    model_step(bus.req_pc, bus.req_valid, bus.hold, bus.flush, m_busy);
    #1;
  endtask

  task automatic check_resp(input string tag);
    chk({tag, "_out"},   bus.instr_out, m_out);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'(m_valid));
    chk({tag, "_mis"},   32'(bus.fault_misaligned), 32'(m_mis));
    chk({tag, "_rng"},   32'(bus.fault_range), 32'(m_rng));
    if (m_valid && !m_rng) chk({tag, "_pc"}, bus.instr_pc, m_pc);
`ifdef IMEM_PARITY_EN
    chk({tag, "_perr"}, 32'(bus.parity_err), 32'd0);
`endif
  endtask

  task automatic fetch(input logic [31:0] pc, input logic v, input logic h, input logic f);
    bus.req_pc = pc; bus.req_valid = v; bus.hold = h; bus.flush = f;
    cyc();
    bus.req_valid = 1'b0; bus.hold = 1'b0; bus.flush = 1'b0;
  endtask

  task automatic load_start_pulse();
    bus.load_start = 1'b1;
    cyc();
    bus.load_start = 1'b0;
    m_busy = 1'b1; ld_addr = 0; ld_count = 0; ld_nbytes = 0;
  endtask

  task automatic load_end_pulse();
    bus.load_end = 1'b1;
    cyc();
    bus.load_end = 1'b0;
    m_busy = 1'b0; ld_nbytes = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int unsigned waited = 0;
    while (!bus.load_ready && waited < 8) begin
      cyc();
      waited++;
    end
    if (!bus.load_ready) begin
      total++; bad++;
      $display("FAIL load_ready_wait: actual=0 required=1");
      return;
    end
    bus.load_valid = 1'b1; bus.load_byte = b;
    cyc();
    bus.load_valid = 1'b0;
    ld_word[8*ld_nbytes +: 8] = b;
    ld_nbytes++;
    if (ld_nbytes == 4) begin
      ref_mem[AWT'(ld_addr)] = ld_word;
      ld_addr++; ld_count++; ld_nbytes = 0;
    end
  endtask

  task automatic send_word(input logic [31:0] w);
    for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8]);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_out"},   bus.instr_out, NOP);
    chk({tag, "_pc"},    bus.instr_pc, 32'd0);
    chk({tag, "_valid"}, 32'(bus.instr_valid), 32'd0);
    chk({tag, "_mis"},   32'(bus.fault_misaligned), 32'd0);
    chk({tag, "_rng"},   32'(bus.fault_range), 32'd0);
    chk({tag, "_ready"}, 32'(bus.load_ready), 32'd0);
    chk({tag, "_busy"},  32'(bus.load_busy), 32'd0);
    chk({tag, "_count"}, 32'(bus.load_count), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    bus.req_pc = '0; bus.req_valid = 1'b0; bus.hold = 1'b0; bus.flush = 1'b0;
    bus.load_start = 1'b0; bus.load_end = 1'b0; bus.load_valid = 1'b0; bus.load_byte = '0;
    m_out = NOP; m_pc = '0; m_valid = 1'b0; m_mis = 1'b0; m_rng = 1'b0; m_busy = 1'b0;
    ld_addr = 0; ld_count = 0; ld_nbytes = 0; ld_word = '0;
    for (int i = 0; i < int'(DEPTH); i++) ref_mem[i] = '0;

    vt[0]  = mk(32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    vt[1]  = mk(32'h0000_0004, 1'b1, 1'b0, 1'b0, 32'h0010_0093, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b1);
    vt[2]  = mk(32'h0000_0008, 1'b1, 1'b1, 1'b0, 32'h0010_0093, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b1);
    vt[3]  = mk(32'h0000_0008, 1'b1, 1'b1, 1'b0, 32'h0010_0093, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b1);
    vt[4]  = mk(32'h0000_0008, 1'b1, 1'b1, 1'b0, 32'h0010_0093, 32'h0000_0004, 1'b1, 1'b0, 1'b0, 1'b1);
    vt[5]  = mk(32'h0000_000C, 1'b1, 1'b1, 1'b1, NOP,           32'h0000_000C, 1'b0, 1'b0, 1'b0, 1'b1);
    vt[6]  = mk(32'h0000_0006, 1'b1, 1'b0, 1'b0, NOP,           32'h0000_0006, 1'b1, 1'b1, 1'b0, 1'b1);
    vt[7]  = mk(32'h0000_1000, 1'b1, 1'b0, 1'b0, NOP,           32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    vt[8]  = mk(32'h0000_1002, 1'b1, 1'b0, 1'b0, NOP,           32'h0000_1002, 1'b1, 1'b1, 1'b0, 1'b1);
    vt[9]  = mk(32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0, NOP,           32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0);
    vt[10] = mk(32'h0000_0000, 1'b0, 1'b0, 1'b0, NOP,           32'h0000_0000, 1'b0, 1'b0, 1'b0, 1'b0);
    vt[11] = mk(32'h0000_0004, 1'b1, 1'b0, 1'b1, NOP,           32'h0000_0004, 1'b0, 1'b0, 1'b0, 1'b1);
    vt[12] = mk(32'h0000_0000, 1'b1, 1'b0, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);
    vt[13] = mk(32'h0000_0007, 1'b1, 1'b1, 1'b0, 32'h0000_0013, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1);

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("reset");
    rst = 1'b0;

    // basic two-word load
    load_start_pulse();
    send_word(32'h0000_0013);
    send_word(32'h0010_0093);
    load_end_pulse();
    chk("load2_count", 32'(bus.load_count), 32'd2);
    chk("load2_busy",  32'(bus.load_busy), 32'd0);

    // table: reads, hold, flush, faults
    for (int i = 0; i < 14; i++) begin
      fetch(vt[i].pc, vt[i].v, vt[i].h, vt[i].f);
      chk($sformatf("vec%0d_out", i),   bus.instr_out, vt[i].eout);
      chk($sformatf("vec%0d_valid", i), 32'(bus.instr_valid), 32'(vt[i].ev));
      chk($sformatf("vec%0d_mis", i),   32'(bus.fault_misaligned), 32'(vt[i].em));
      chk($sformatf("vec%0d_rng", i),   32'(bus.fault_range), 32'(vt[i].er));
      if (vt[i].cpc) chk($sformatf("vec%0d_pc", i), bus.instr_pc, vt[i].epc);
    end

    // partial word discarded; fetch suppressed while loading
    load_start_pulse();
    send_word(32'hCAFE_0013);
    send_byte(8'hEE); send_byte(8'hEE);
    fetch(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    chk("busy_fetch_valid", 32'(bus.instr_valid), 32'd0);
    chk("busy_fetch_out", bus.instr_out, NOP);
    send_byte(8'hEE);
    load_end_pulse();
    chk("partial_count", 32'(bus.load_count), 32'd1);
    chk("partial_busy",  32'(bus.load_busy), 32'd0);
    fetch(32'h0000_0004, 1'b1, 1'b0, 1'b0);
    check_resp("partial_w1");
    chk("partial_w1_lit", bus.instr_out, 32'h0010_0093);
    fetch(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    check_resp("partial_w0");

    // random traffic against the reference model
    load_start_pulse();
    for (int w = 0; w < 16; w++) send_word($urandom);
    load_end_pulse();
    chk("rnd_count", 32'(bus.load_count), 32'd16);
    for (int i = 0; i < 400; i++) begin
      logic [31:0] pc;
      int unsigned r;
      r = $urandom_range(0, 9);
      if (r < 6)      pc = 32'($urandom_range(0, 15)) << 2;
      else if (r < 8) pc = (32'($urandom_range(0, 15)) << 2) | 32'($urandom_range(1, 3));
      else            pc = 32'($urandom_range(DEPTH, 32'h3FFF_FFFF)) << 2;
      fetch(pc, ($urandom_range(0, 99) < 85), ($urandom_range(0, 99) < 15),
            ($urandom_range(0, 99) < 10));
      check_resp($sformatf("rnd%0d", i));
    end

    // fill the whole memory, then extra bytes must be refused
    load_start_pulse();
    for (int k = 0; k < int'(DEPTH); k++) send_word((32'(k) * 32'h9E37_79B1) ^ 32'h0000_0013);
    cyc();
    m_busy = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.load_valid = 1'b1; bus.load_byte = 8'hA5;
      cyc();
      chk($sformatf("full_extra%0d_ready", i), 32'(bus.load_ready), 32'd0);
      chk($sformatf("full_extra%0d_busy", i),  32'(bus.load_busy), 32'd0);
    end
    bus.load_valid = 1'b0;
    chk("full_count", 32'(bus.load_count), DEPTH);
    fetch(32'h0000_0000, 1'b1, 1'b0, 1'b0);
    check_resp("full_w0");
    fetch((DEPTH - 1) * 4, 1'b1, 1'b0, 1'b0);
    check_resp("full_wlast");

    // async reset in the middle of collecting a word
    fetch(32'd28, 1'b1, 1'b0, 1'b0);
    check_resp("pre_rst");
    bus.hold = 1'b1;
    load_start_pulse();
    send_byte(8'h11); send_byte(8'h22);
    check_resp("held_in_load");
    #3;
    rst = 1'b1;
    #1;
    chk_reset_outputs("async_rst");
    m_out = NOP; m_pc = '0; m_valid = 1'b0; m_mis = 1'b0; m_rng = 1'b0; m_busy = 1'b0;
    ld_nbytes = 0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.hold = 1'b0;
    fetch(32'd28, 1'b1, 1'b0, 1'b0);
    check_resp("post_rst_w7");
    fetch(32'd0, 1'b1, 1'b0, 1'b0);
    check_resp("post_rst_w0");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
